dac_sample_scheduler: RTL
=========================

DAC_SAMPLE_SCHEDULER -- requirements
Module: dac_sample_scheduler

Interface
REQ-001 Parameter DEPTH, 16: sample FIFO depth in entries; power of two, 4..64.
REQ-002 Parameter RELEASE_CYC, 4: clk100mhz cycles dac_st_wrt is held low after each transfer.
REQ-003 Parameter TIMEOUT_CYC, 8192: maximum clk100mhz cycles to wait for dac_done before aborting.
REQ-004 clk100mhz  in  1  sole clock, 100 MHz; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 s_valid  in  1  upstream sample valid.
REQ-007 s_data  in  12  upstream unsigned DAC code.
REQ-008 s_ready  out  1  FIFO can accept a sample this cycle.
REQ-009 enable  in  1  playback enable; level-sensitive.
REQ-010 rate_div  in  16  sample period minus one, in clk100mhz cycles; sampled at each tick.
REQ-011 dac_st_wrt  out  1  start/hold-run strobe to the SPI DAC writer; low forces that writer idle.
REQ-012 dac_data_in  out  12  code presented to the DAC writer.
REQ-013 dac_done  in  1  transfer-complete from the DAC writer; asynchronous to this logic's timing, treated as unsynchronized.
REQ-014 fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 underrun  out  1  sticky: tick occurred with FIFO empty.
REQ-016 overrun  out  1  sticky: tick occurred while a transfer was still in progress.
REQ-017 timeout_err  out  1  sticky: dac_done not seen within TIMEOUT_CYC.

Function
REQ-018 Push occurs when s_valid && s_ready; s_ready SHALL equal (fifo_level < DEPTH), registered-level based.
REQ-019 FIFO SHALL be first-in first-out; push and pop in the same cycle SHALL leave fifo_level unchanged and preserve order; push when full is impossible by s_ready; pop SHALL only occur when fifo_level != 0.
REQ-020 Rate timer SHALL count 0..rate_div while enable=1, emitting a one-cycle tick on reaching rate_div and restarting at 0; enable=0 holds timer at 0 with no ticks; rate_div=0 ticks every cycle.
REQ-021 dac_done SHALL pass through a 2-flop synchronizer; done_rise = rising edge of the synchronized signal.
REQ-022 FSM states: IDLE, LOAD, BUSY, RELEASE.
REQ-023 IDLE: on tick with fifo_level != 0, pop head into dac_data_in register, go LOAD; on tick with FIFO empty, set underrun, stay IDLE, dac_data_in unchanged.
REQ-024 LOAD: assert dac_st_wrt=1 next cycle, clear busy counter, go BUSY (pop-to-st_wrt latency exactly 1 cycle).
REQ-025 BUSY: dac_st_wrt=1, dac_data_in stable; on done_rise go RELEASE; if busy counter reaches TIMEOUT_CYC, set timeout_err and go RELEASE.
REQ-026 RELEASE: dac_st_wrt=0 for exactly RELEASE_CYC cycles, then IDLE.
REQ-027 Tick arriving in LOAD, BUSY or RELEASE SHALL set overrun and be discarded (no pop, no queued retry).
REQ-028 enable falling mid-transfer SHALL NOT abort; current transfer completes through RELEASE, then FSM idles.
REQ-029 Sticky flags clear only on rst.

Reset
REQ-030 On rst: FSM=IDLE, FIFO empty, fifo_level=0, s_ready=0 while rst asserted then 1, timer=0, dac_st_wrt=0, dac_data_in=12'h000, underrun=overrun=timeout_err=0, synchronizer flops=0.
REQ-031 rst asserted mid-transfer SHALL drop dac_st_wrt immediately (asynchronously) and discard FIFO contents.

Verification
REQ-032 Push 0x123,0x456,0xABC, rate_div=999, enable=1, DAC model returns done 400 cycles after st_wrt -> dac_data_in sequence 0x123,0x456,0xABC, one transfer per 1000 cycles, no flags.
REQ-033 Push 17 samples back-to-back with DEPTH=16, enable=0 -> s_ready low after 16th, fifo_level=16, 17th held until a pop.
REQ-034 enable=1 with empty FIFO, rate_div=99 -> underrun=1 after first tick, dac_st_wrt stays 0.
REQ-035 rate_div=49, DAC done after 400 cycles -> overrun=1, no extra pops, samples still output in order.
REQ-036 DAC model never asserts done -> dac_st_wrt drops after 8192 BUSY cycles, timeout_err=1, next sample proceeds on following tick.
REQ-037 Assert rst during BUSY -> dac_st_wrt=0 same cycle, fifo_level=0, all flags 0.

Source files
------------

// File: rtl/dac_sample_scheduler.sv
// Sample FIFO feeding an SPI DAC writer at a programmable rate; one transfer per tick.
// Latency: pop-to-dac_st_wrt 1 cycle; backpressure: s_ready drops when the FIFO is full.
// Ticks that find the FIFO empty or a transfer in flight are dropped and flagged (sticky).
module dac_sample_scheduler #(
    parameter int DEPTH       = 16,
    parameter int RELEASE_CYC = 4,
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic                     clk100mhz,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic [11:0]              s_data,
    output logic                     s_ready,
    input  logic                     enable,
    input  logic [15:0]              rate_div,
    output logic                     dac_st_wrt,
    output logic [11:0]              dac_data_in,
    input  logic                     dac_done,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     underrun,
    output logic                     overrun,
    output logic                     timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, BUSY, RELEASE} state_t;

    state_t          state_q, state_d;
    logic [11:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            push, pop;
    logic [15:0]     tmr;
    logic            tick;
    logic            done_s1, done_s2, done_s3, done_rise;
    logic [CW-1:0]   cyc_cnt;
    logic            set_under, set_over, set_to;

    assign s_ready = !rst && (fifo_level < (AW+1)'(DEPTH));
    assign push    = s_valid && s_ready;

    always_ff @(posedge clk100mhz) begin
        if (push)
            mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk100mhz or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // >= rather than == so a rate_div lowered mid-period cannot leave the timer running away
    assign tick = enable && (tmr >= rate_div);

    always_ff @(posedge clk100mhz or posedge rst) begin
        if (rst)
            tmr <= '0;
        else if (!enable || tick)
            tmr <= '0;
        else
            tmr <= tmr + 16'd1;
    end

    always_ff @(posedge clk100mhz or posedge rst) begin
        if (rst) begin
            done_s1 <= 1'b0;
            done_s2 <= 1'b0;
            done_s3 <= 1'b0;
        end else begin
            done_s1 <= dac_done;
            done_s2 <= done_s1;
            done_s3 <= done_s2;
        end
    end

    assign done_rise = done_s2 && !done_s3;

    always_ff @(posedge clk100mhz or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        set_under = 1'b0;
        set_over  = 1'b0;
        set_to    = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    if (fifo_level != '0) begin
                        pop     = 1'b1;
                        state_d = LOAD;
                    end else begin
                        set_under = 1'b1;
                    end
                end
            end
            LOAD: begin
                set_over = tick;
                state_d  = BUSY;
            end
            BUSY: begin
                set_over = tick;
                if (done_rise) begin
                    state_d = RELEASE;
                end else if (cyc_cnt == CW'(TIMEOUT_CYC - 1)) begin
                    set_to  = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                set_over = tick;
                if (cyc_cnt == CW'(RELEASE_CYC - 1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // One counter serves both the BUSY timeout and the RELEASE hold; it restarts on every state change
    always_ff @(posedge clk100mhz or posedge rst) begin
        if (rst)
            cyc_cnt <= '0;
        else if (state_d != state_q)
            cyc_cnt <= '0;
        else if (state_q == BUSY || state_q == RELEASE)
            cyc_cnt <= cyc_cnt + 1'b1;
    end

    always_ff @(posedge clk100mhz or posedge rst) begin
        if (rst) begin
            dac_st_wrt  <= 1'b0;
            dac_data_in <= 12'h000;
            underrun    <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            dac_st_wrt <= (state_d == BUSY);
            if (pop)
                dac_data_in <= mem[rd_ptr];
            if (set_under)
                underrun <= 1'b1;
            if (set_over)
                overrun <= 1'b1;
            if (set_to)
                timeout_err <= 1'b1;
        end
    end
endmodule
